// File: rtl/ex_stage.sv
//==============================================================================
// Module   : ex_stage
// Brief    : Pipeline execute stage: ALU, 32-iteration restoring divider, SRAM
//            request at handoff. Optional multiplier under CPU_EX_MULTIPLY_EN.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module ex_stage #(
  parameter int DIV_CYCLES = 32
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        io_allow_in,
  output logic        ex_allow_in,
  input  logic        id_valid,
  input  logic [31:0] id_pc,
  input  logic [3:0]  alu_op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic [31:0] store_data,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [4:0]  dest_reg,
  input  logic        reg_write,
  input  logic        div_valid,
  input  logic        div_signed,
  output logic        ex_to_io_valid,
  output logic [31:0] ex_pc,
  output logic [31:0] alu_result,
  output logic [4:0]  ex_dest_reg,
  output logic        ex_reg_write,
  output logic        ex_mem_read,
  output logic        div_result_valid,
  output logic [31:0] div_quotient,
  output logic [31:0] div_remainder,
  output logic [63:0] mul_result,
  output logic        data_sram_en,
  output logic [3:0]  data_sram_wen,
  output logic [31:0] data_sram_addr,
  output logic [31:0] data_sram_wdata
);

  localparam int CNT_W = $clog2(DIV_CYCLES);
  localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(DIV_CYCLES - 1);

  localparam logic [3:0] c_op_add  = 4'd0;
  localparam logic [3:0] c_op_sub  = 4'd1;
  localparam logic [3:0] c_op_and  = 4'd2;
  localparam logic [3:0] c_op_or   = 4'd3;
  localparam logic [3:0] c_op_xor  = 4'd4;
  localparam logic [3:0] c_op_nor  = 4'd5;
  localparam logic [3:0] c_op_slt  = 4'd6;
  localparam logic [3:0] c_op_sltu = 4'd7;
  localparam logic [3:0] c_op_sll  = 4'd8;
  localparam logic [3:0] c_op_srl  = 4'd9;
  localparam logic [3:0] c_op_sra  = 4'd10;
  localparam logic [3:0] c_op_lui  = 4'd11;
  localparam logic [3:0] c_op_mul  = 4'd12;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } div_state_t;

  // Latched instruction fields
  logic        r_ex_valid;
  logic [31:0] r_pc;
  logic [3:0]  r_op;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [31:0] r_sd;
  logic        r_mr;
  logic        r_mw;
  logic [4:0]  r_dest;
  logic        r_rw;
  logic        r_div;
  logic        r_div_signed;

  // Divider state
  div_state_t       r_state;
  div_state_t       w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [31:0]      r_quo;
  logic [31:0]      r_rem;
  logic [31:0]      r_dvsr;
  logic [31:0]      r_dend;
  logic             r_neg_q;
  logic             r_neg_r;
  logic             r_dzero;

  logic        w_ready_go;
  logic        w_handoff;
  logic        w_start;
  logic [31:0] w_abs_a;
  logic [31:0] w_abs_b;
  logic [32:0] w_shift;
  logic [32:0] w_diff;
  logic        w_fits;
  logic [31:0] w_alu;

  assign w_ready_go     = !r_div || (r_state == S_DONE);
  assign ex_allow_in    = !r_ex_valid || (w_ready_go && io_allow_in);
  assign ex_to_io_valid = r_ex_valid && w_ready_go;
  assign w_handoff      = ex_to_io_valid && io_allow_in;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_ex_valid <= 1'b0;
    end else if (ex_allow_in) begin
      r_ex_valid <= id_valid;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_pc         <= '0;
      r_op         <= '0;
      r_a          <= '0;
      r_b          <= '0;
      r_sd         <= '0;
      r_mr         <= 1'b0;
      r_mw         <= 1'b0;
      r_dest       <= '0;
      r_rw         <= 1'b0;
      r_div        <= 1'b0;
      r_div_signed <= 1'b0;
    end else if (id_valid && ex_allow_in) begin
      r_pc         <= id_pc;
      r_op         <= alu_op;
      r_a          <= src_a;
      r_b          <= src_b;
      r_sd         <= store_data;
      r_mr         <= mem_read;
      r_mw         <= mem_write;
      r_dest       <= dest_reg;
      r_rw         <= reg_write;
      r_div        <= div_valid;
      r_div_signed <= div_signed;
    end
  end

  // ALU
`ifdef CPU_EX_MULTIPLY_EN
  logic signed [63:0] w_mul;
  assign w_mul      = $signed(r_a) * $signed(r_b);
  assign mul_result = (r_op == c_op_mul) ? w_mul : 64'd0;
`else
  assign mul_result = 64'd0;
`endif

  always_comb begin
    w_alu = 32'd0;
    case (r_op)
      c_op_add:  w_alu = r_a + r_b;
      c_op_sub:  w_alu = r_a - r_b;
      c_op_and:  w_alu = r_a & r_b;
      c_op_or:   w_alu = r_a | r_b;
      c_op_xor:  w_alu = r_a ^ r_b;
      c_op_nor:  w_alu = ~(r_a | r_b);
      c_op_slt:  w_alu = {31'd0, ($signed(r_a) < $signed(r_b))};
      c_op_sltu: w_alu = {31'd0, (r_a < r_b)};
      c_op_sll:  w_alu = r_b << r_a[4:0];
      c_op_srl:  w_alu = r_b >> r_a[4:0];
      c_op_sra:  w_alu = $unsigned($signed(r_b) >>> r_a[4:0]);
      c_op_lui:  w_alu = {r_b[15:0], 16'h0000};
`ifdef CPU_EX_MULTIPLY_EN
      c_op_mul:  w_alu = w_mul[31:0];
`endif
      default:   w_alu = 32'd0;
    endcase
  end

  assign alu_result   = w_alu;
  assign ex_pc        = r_pc;
  assign ex_dest_reg  = r_dest;
  assign ex_reg_write = r_rw;
  assign ex_mem_read  = r_mr;

  // Divider FSM
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (r_ex_valid && r_div) w_next = S_BUSY;
      S_BUSY:  if (r_cnt == c_cnt_last) w_next = S_DONE;
      S_DONE:  if (w_handoff) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  assign w_start = (r_state == S_IDLE) && (w_next == S_BUSY);
  assign w_abs_a = (r_div_signed && r_a[31]) ? (32'd0 - r_a) : r_a;
  assign w_abs_b = (r_div_signed && r_b[31]) ? (32'd0 - r_b) : r_b;

  // One restoring step: shift next dividend bit in, subtract if it fits
  assign w_shift = {r_rem, r_quo[31]};
  assign w_diff  = w_shift - {1'b0, r_dvsr};
  assign w_fits  = !w_diff[32];

  always_ff @(posedge clock) begin
    if (reset) begin
      r_cnt   <= '0;
      r_quo   <= '0;
      r_rem   <= '0;
      r_dvsr  <= '0;
      r_dend  <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_dzero <= 1'b0;
    end else if (w_start) begin
      r_cnt   <= '0;
      r_quo   <= w_abs_a;
      r_rem   <= '0;
      r_dvsr  <= w_abs_b;
      r_dend  <= r_a;
      r_neg_q <= r_div_signed && (r_a[31] ^ r_b[31]);
      r_neg_r <= r_div_signed && r_a[31];
      r_dzero <= (r_b == 32'd0);
    end else if (r_state == S_BUSY) begin
      r_cnt <= r_cnt + CNT_W'(1);
      r_quo <= {r_quo[30:0], w_fits};
      r_rem <= w_fits ? w_diff[31:0] : w_shift[31:0];
    end
  end

  // Divide by zero bypasses the sign fix-up entirely
  assign div_quotient     = r_dzero ? 32'hFFFF_FFFF : (r_neg_q ? (32'd0 - r_quo) : r_quo);
  assign div_remainder    = r_dzero ? r_dend : (r_neg_r ? (32'd0 - r_rem) : r_rem);
  assign div_result_valid = (r_state == S_DONE);

  // Data SRAM request, issued once at handoff
  assign data_sram_en    = w_handoff && (r_mr || r_mw);
  assign data_sram_wen   = r_mw ? 4'hF : 4'h0;
  assign data_sram_addr  = w_alu;
  assign data_sram_wdata = r_sd;

endmodule

`default_nettype wire

// File: tb/tb_ex_stage.sv
//==============================================================================
// Module   : tb_ex_stage
// Brief    : Directed self-checking bench for ex_stage.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_ex_stage;

  logic        clock;
  logic        reset;
  logic        io_allow_in;
  logic        ex_allow_in;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [3:0]  alu_op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic [31:0] store_data;
  logic        mem_read;
  logic        mem_write;
  logic [4:0]  dest_reg;
  logic        reg_write;
  logic        div_valid;
  logic        div_signed;
  logic        ex_to_io_valid;
  logic [31:0] ex_pc;
  logic [31:0] alu_result;
  logic [4:0]  ex_dest_reg;
  logic        ex_reg_write;
  logic        ex_mem_read;
  logic        div_result_valid;
  logic [31:0] div_quotient;
  logic [31:0] div_remainder;
  logic [63:0] mul_result;
  logic        data_sram_en;
  logic [3:0]  data_sram_wen;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;

  int n_vec = 0;
  int n_err = 0;

  ex_stage #(.DIV_CYCLES(32)) u_dut (
    .clock(clock), .reset(reset), .io_allow_in(io_allow_in), .ex_allow_in(ex_allow_in),
    .id_valid(id_valid), .id_pc(id_pc), .alu_op(alu_op), .src_a(src_a), .src_b(src_b),
    .store_data(store_data), .mem_read(mem_read), .mem_write(mem_write),
    .dest_reg(dest_reg), .reg_write(reg_write), .div_valid(div_valid), .div_signed(div_signed),
    .ex_to_io_valid(ex_to_io_valid), .ex_pc(ex_pc), .alu_result(alu_result),
    .ex_dest_reg(ex_dest_reg), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .div_result_valid(div_result_valid), .div_quotient(div_quotient),
    .div_remainder(div_remainder), .mul_result(mul_result), .data_sram_en(data_sram_en),
    .data_sram_wen(data_sram_wen), .data_sram_addr(data_sram_addr),
    .data_sram_wdata(data_sram_wdata)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Present one instruction for a single edge
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] sd, input logic mr, input logic mw,
                       input logic dv, input logic ds);
    id_valid   = 1'b1;
    id_pc      = id_pc + 32'd4;
    alu_op     = op;
    src_a      = a;
    src_b      = b;
    store_data = sd;
    mem_read   = mr;
    mem_write  = mw;
    dest_reg   = 5'd3;
    reg_write  = 1'b1;
    div_valid  = dv;
    div_signed = ds;
    step();
    id_valid   = 1'b0;
  endtask

  // Count edges from latch until the divide result appears (bounded)
  task automatic wait_div(output int k, output int stall_bad);
    k = 0;
    stall_bad = 0;
    while (!div_result_valid && k < 100) begin
      if (ex_allow_in || ex_to_io_valid) stall_bad++;
      step();
      k++;
    end
  endtask

  logic [3:0]  t_op  [14];
  logic [31:0] t_a   [14];
  logic [31:0] t_b   [14];
  logic [31:0] t_exp [14];

  initial begin
    int k;
    int bad;
    int ev;
    logic [31:0] q0;
    logic [31:0] r0;

    t_op[0]  = 4'd0;  t_a[0]  = 32'h7FFF_FFFF; t_b[0]  = 32'h1;         t_exp[0]  = 32'h8000_0000;
    t_op[1]  = 4'd6;  t_a[1]  = 32'hFFFF_FFFF; t_b[1]  = 32'h1;         t_exp[1]  = 32'h1;
    t_op[2]  = 4'd7;  t_a[2]  = 32'hFFFF_FFFF; t_b[2]  = 32'h1;         t_exp[2]  = 32'h0;
    t_op[3]  = 4'd1;  t_a[3]  = 32'h5;         t_b[3]  = 32'h7;         t_exp[3]  = 32'hFFFF_FFFE;
    t_op[4]  = 4'd2;  t_a[4]  = 32'hF0F0;      t_b[4]  = 32'hFF00;      t_exp[4]  = 32'hF000;
    t_op[5]  = 4'd3;  t_a[5]  = 32'hF0;        t_b[5]  = 32'h0F;        t_exp[5]  = 32'hFF;
    t_op[6]  = 4'd4;  t_a[6]  = 32'hFF;        t_b[6]  = 32'h0F;        t_exp[6]  = 32'hF0;
    t_op[7]  = 4'd5;  t_a[7]  = 32'h0;         t_b[7]  = 32'h0;         t_exp[7]  = 32'hFFFF_FFFF;
    t_op[8]  = 4'd8;  t_a[8]  = 32'h24;        t_b[8]  = 32'h1;         t_exp[8]  = 32'h10;
    t_op[9]  = 4'd9;  t_a[9]  = 32'h4;         t_b[9]  = 32'h8000_0000; t_exp[9]  = 32'h0800_0000;
    t_op[10] = 4'd10; t_a[10] = 32'h4;         t_b[10] = 32'h8000_0000; t_exp[10] = 32'hF800_0000;
    t_op[11] = 4'd11; t_a[11] = 32'h0;         t_b[11] = 32'hABCD_1234; t_exp[11] = 32'h1234_0000;
    t_op[12] = 4'd13; t_a[12] = 32'h1;         t_b[12] = 32'h2;         t_exp[12] = 32'h0;
    t_op[13] = 4'd6;  t_a[13] = 32'h1;         t_b[13] = 32'hFFFF_FFFF; t_exp[13] = 32'h0;

    reset = 1'b1; io_allow_in = 1'b1; id_valid = 1'b0; id_pc = 32'h0; alu_op = 4'd0;
    src_a = '0; src_b = '0; store_data = '0; mem_read = 1'b0; mem_write = 1'b0;
    dest_reg = '0; reg_write = 1'b0; div_valid = 1'b0; div_signed = 1'b0;
    repeat (3) step();
    chk("rst_to_io_valid", {63'd0, ex_to_io_valid}, 64'd0);
    chk("rst_div_valid",   {63'd0, div_result_valid}, 64'd0);
    chk("rst_sram_en",     {63'd0, data_sram_en}, 64'd0);
    chk("rst_allow_in",    {63'd0, ex_allow_in}, 64'd1);
    chk("rst_quotient",    {32'd0, div_quotient}, 64'd0);
    reset = 1'b0;
    step();

    // ALU ops, back-to-back through the stage
    for (int i = 0; i < 14; i++) begin
      issue(t_op[i], t_a[i], t_b[i], 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk($sformatf("alu_op%0d_%0d", t_op[i], i), {32'd0, alu_result}, {32'd0, t_exp[i]});
      chk($sformatf("alu_vld_%0d", i), {63'd0, ex_to_io_valid}, 64'd1);
      if (i == 0) begin
        chk("alu_pc",   {32'd0, ex_pc}, {32'd0, id_pc});
        chk("alu_dest", {59'd0, ex_dest_reg}, 64'd3);
      end
    end

    // MUL: -3 * 4
    issue(4'd12, 32'hFFFF_FFFD, 32'h4, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
`ifdef CPU_EX_MULTIPLY_EN
    chk("mul_result", mul_result, 64'hFFFF_FFFF_FFFF_FFF4);
    chk("mul_alu",    {32'd0, alu_result}, 64'hFFFF_FFF4);
`else
    chk("mul_result", mul_result, 64'd0);
    chk("mul_alu",    {32'd0, alu_result}, 64'd0);
`endif
    step();
    chk("alu_drain", {63'd0, ex_to_io_valid}, 64'd0);

    // Unsigned 100/7, then signed -7/2 issued on the handoff edge
    issue(4'd0, 32'd100, 32'd7, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    wait_div(k, bad);
    chk("div_u_latency", 64'(k), 64'd33);
    chk("div_u_stall",   64'(bad), 64'd0);
    chk("div_u_q", {32'd0, div_quotient},  64'd14);
    chk("div_u_r", {32'd0, div_remainder}, 64'd2);
    issue(4'd0, 32'hFFFF_FFF9, 32'd2, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("b2b_idle", {63'd0, div_result_valid}, 64'd0);
    wait_div(k, bad);
    chk("div_s_latency", 64'(k), 64'd33);
    chk("div_s_q", {32'd0, div_quotient},  64'hFFFF_FFFD);
    chk("div_s_r", {32'd0, div_remainder}, 64'hFFFF_FFFF);
    step();
    chk("div_s_after", {63'd0, div_result_valid}, 64'd0);

    // Divide by zero, unsigned and signed
    issue(4'd0, 32'd5, 32'd0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    wait_div(k, bad);
    chk("dz_u_latency", 64'(k), 64'd33);
    chk("dz_u_q", {32'd0, div_quotient},  64'hFFFF_FFFF);
    chk("dz_u_r", {32'd0, div_remainder}, 64'd5);
    step();
    issue(4'd0, 32'hFFFF_FFFB, 32'd0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1);
    wait_div(k, bad);
    chk("dz_s_q", {32'd0, div_quotient},  64'hFFFF_FFFF);
    chk("dz_s_r", {32'd0, div_remainder}, 64'hFFFF_FFFB);
    step();

    // Overflow case 0x80000000 / -1
    issue(4'd0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1);
    wait_div(k, bad);
    chk("ovf_q", {32'd0, div_quotient},  64'h8000_0000);
    chk("ovf_r", {32'd0, div_remainder}, 64'd0);
    step();

    // DONE held under backpressure: 1000/10
    io_allow_in = 1'b0;
    issue(4'd0, 32'd1000, 32'd10, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    wait_div(k, bad);
    chk("bp_latency", 64'(k), 64'd33);
    q0 = div_quotient;
    r0 = div_remainder;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (!div_result_valid || !ex_to_io_valid || ex_allow_in ||
          div_quotient != 32'd100 || div_remainder != 32'd0) bad++;
    end
    chk("bp_stable", 64'(bad), 64'd0);
    chk("bp_q", {32'd0, q0}, 64'd100);
    chk("bp_r", {32'd0, r0}, 64'd0);
    io_allow_in = 1'b1;
    #1;
    chk("bp_allow", {63'd0, ex_allow_in}, 64'd1);
    step();
    chk("bp_idle",  {63'd0, div_result_valid}, 64'd0);
    chk("bp_single", {63'd0, ex_to_io_valid}, 64'd0);

    // Store held 3 cycles, exactly one SRAM request
    io_allow_in = 1'b0;
    issue(4'd0, 32'h1000, 32'h0, 32'hDEAD_BEEF, 1'b0, 1'b1, 1'b0, 1'b0);
    ev = 0;
    for (int i = 0; i < 3; i++) begin
      if (data_sram_en) ev++;
      step();
    end
    io_allow_in = 1'b1;
    #1;
    if (data_sram_en) ev++;
    chk("st_wen",   {60'd0, data_sram_wen}, 64'hF);
    chk("st_addr",  {32'd0, data_sram_addr}, 64'h1000);
    chk("st_wdata", {32'd0, data_sram_wdata}, 64'hDEAD_BEEF);
    step();
    if (data_sram_en) ev++;
    step();
    if (data_sram_en) ev++;
    chk("st_pulses", 64'(ev), 64'd1);

    // Reset during BUSY aborts the divide
    issue(4'd0, 32'd100, 32'd7, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0);
    repeat (10) step();
    chk("rb_busy", {63'd0, ex_allow_in}, 64'd0);
    reset = 1'b1;
    step();
    chk("rb_valid", {63'd0, ex_to_io_valid}, 64'd0);
    chk("rb_allow", {63'd0, ex_allow_in}, 64'd1);
    reset = 1'b0;
    ev = 0;
    for (int i = 0; i < 40; i++) begin
      if (div_result_valid || data_sram_en || ex_to_io_valid) ev++;
      step();
    end
    chk("rb_no_result", 64'(ev), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
